// File: rtl/multicycle_control_pkg.sv
// Shared MIPS control definitions: FSM states, opcode/funct constants and ALU codes.
// The single-cycle controller imports this package as well.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE,
        ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JAL, JR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct to ALU operation; legal=0 for any funct the datapath cannot execute.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [4:0] aluControl,
    output logic       legal
);

    always_comb begin
        aluControl = 5'b00000;
        legal      = 1'b1;
        case (funct)
            FN_ADD:  aluControl = ALU_ADD;
            FN_SUB:  aluControl = ALU_SUB;
            FN_AND:  aluControl = ALU_AND;
            FN_OR:   aluControl = ALU_OR;
            FN_SLT:  aluControl = ALU_SLT;
            default: legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: one state register, separate next-state and output decode.
// Outputs are combinational from state, memReady, zero and funct.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcEn,
    output logic       iorD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic       illegalOp,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic [1:0] aluSrcB,
    output logic [4:0] aluControl,
    output logic [1:0] pcSrc,
    output logic [3:0] state
);

    state_t     cur, nxt;
    logic [4:0] dec_alu;
    logic       dec_legal;
    logic       op_known;

    alu_decoder u_alu_decoder (
        .funct      (funct),
        .aluControl (dec_alu),
        .legal      (dec_legal)
    );

    assign op_known = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL};
    assign state    = cur;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cur <= FETCH;
        else          cur <= nxt;
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:    nxt = memReady ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = (funct == FN_JR) ? JR : EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    OP_JAL:       nxt = JAL;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR:   nxt = (opcode == OP_SW) ? MEMWRITE : (opcode == OP_LW) ? MEMREAD : FETCH;
            MEMREAD:  nxt = memReady ? MEMWB : MEMREAD;
            MEMWRITE: nxt = memReady ? FETCH : MEMWRITE;
            EXECUTE:  nxt = dec_legal ? ALUWB : FETCH;
            ADDIEX:   nxt = ADDIWB;
            default:  nxt = FETCH;
        endcase
    end

    always_comb begin
        pcEn       = 1'b0;
        iorD       = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        illegalOp  = 1'b0;
        regDst     = 2'b00;
        memToReg   = 2'b00;
        aluSrcB    = 2'b00;
        aluControl = 5'b00000;
        pcSrc      = 2'b00;
        case (cur)
            FETCH: begin
                aluSrcB    = 2'b01;
                aluControl = ALU_ADD;
                irWrite    = memReady;
                pcEn       = memReady;
            end
            DECODE: begin
                aluSrcB    = 2'b11;
                aluControl = ALU_ADD;
                illegalOp  = !op_known;
            end
            MEMADR, ADDIEX: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
            end
            MEMREAD:  iorD = 1'b1;
            MEMWB: begin
                regWrite = 1'b1;
                memToReg = 2'b01;
            end
            MEMWRITE: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
            end
            EXECUTE: begin
                aluSrcA    = 1'b1;
                aluControl = dec_alu;
                illegalOp  = !dec_legal;
            end
            ALUWB: begin
                regWrite = 1'b1;
                regDst   = 2'b01;
            end
            BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                pcSrc      = 2'b01;
                pcEn       = zero;
            end
            ADDIWB:   regWrite = 1'b1;
            JUMP: begin
                pcSrc = 2'b10;
                pcEn  = 1'b1;
            end
            JAL: begin
                regWrite = 1'b1;
                regDst   = 2'b10;
                memToReg = 2'b10;
                pcSrc    = 2'b10;
                pcEn     = 1'b1;
            end
            JR: begin
                pcSrc = 2'b11;
                pcEn  = 1'b1;
            end
            default: ;
        endcase
        // FETCH decodes memReady, so enables must be forced off while reset is held
        if (!reset_n) begin
            pcEn     = 1'b0;
            irWrite  = 1'b0;
            regWrite = 1'b0;
            memWrite = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clock  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: opcode  in  6  instr[31:26] from the instruction register.
REQ-004 SHALL have port: funct  in  6  instr[5:0] from the instruction register.
REQ-005 SHALL have port: zero  in  1  ALU zero flag.
REQ-006 SHALL have port: memReady  in  1  unified-memory access complete this cycle.
REQ-007 SHALL have output ports, each 1 bit: pcEn, iorD, memWrite, irWrite, regWrite, aluSrcA, illegalOp.
REQ-008 SHALL have port: regDst  out  2  00 rt, 01 rd, 10 r31.
REQ-009 SHALL have port: memToReg  out  2  00 ALUOut, 01 MDR, 10 PC.
REQ-010 SHALL have port: aluSrcB  out  2  00 regB, 01 const 4, 10 SignImm, 11 SignImm<<2.
REQ-011 SHALL have port: aluControl  out  5  ALU operation code.
REQ-012 SHALL have port: pcSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 RD1.
REQ-013 SHALL have port: state  out  4  current state encoding, debug only.

Function
REQ-014 SHALL be an FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JAL, JR.
REQ-015 Every output not listed for a state SHALL be 0 in that state.
REQ-016 FETCH: iorD=0, aluSrcA=0, aluSrcB=01, aluControl=ADD, pcSrc=00; irWrite=pcEn=memReady; stay in FETCH while memReady=0, else go to DECODE.
REQ-017 DECODE: aluSrcA=0, aluSrcB=11, aluControl=ADD; next state by opcode:
- lw 100011 or sw 101011 -> MEMADR
- R-type 000000 with funct 001000 -> JR; other R-type -> EXECUTE
- beq 000100 -> BRANCH
- addi 001000 -> ADDIEX
- j 000010 -> JUMP
- jal 000011 -> JAL
- any other opcode -> FETCH, with illegalOp=1 for that one cycle.
REQ-018 MEMADR: aluSrcA=1, aluSrcB=10, ADD; lw -> MEMREAD, sw -> MEMWRITE.
REQ-019 MEMREAD: iorD=1; wait while memReady=0; on memReady go to MEMWB.
REQ-020 MEMWB: regWrite=1, regDst=00, memToReg=01; go to FETCH.
REQ-021 MEMWRITE: iorD=1, memWrite=1 held until memReady; on memReady go to FETCH.
REQ-022 EXECUTE: aluSrcA=1, aluSrcB=00, aluControl from funct; go to ALUWB.
REQ-023 EXECUTE funct decode SHALL be: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct SHALL raise illegalOp in EXECUTE and go to FETCH without writeback.
REQ-024 ALUWB: regWrite=1, regDst=01, memToReg=00; go to FETCH.
REQ-025 BRANCH: aluSrcA=1, aluSrcB=00, SUB, pcSrc=01, pcEn=zero; go to FETCH.
REQ-026 ADDIEX: aluSrcA=1, aluSrcB=10, ADD; ADDIWB: regWrite=1, regDst=00, memToReg=00; then FETCH.
REQ-027 JUMP: pcSrc=10, pcEn=1; go to FETCH.
REQ-028 JAL: regWrite=1, regDst=10, memToReg=10, pcSrc=10, pcEn=1; go to FETCH. PC already holds PC+4, so the link value is correct.
REQ-029 JR: pcSrc=11, pcEn=1; go to FETCH.
REQ-030 Outputs SHALL be combinational from state plus memReady, zero and funct only; no output SHALL depend on opcode except in DECODE and MEMADR.
REQ-031 A wait on memReady SHALL be unbounded; no timeout.
REQ-032 Instruction latency with memReady=1 throughout SHALL be:
- 5 cycles: lw
- 4 cycles: sw, R-type, addi
- 3 cycles: beq, j, jal, jr

Reset
REQ-033 reset_n=0 SHALL force state to FETCH immediately, independent of clock, with all write enables (pcEn, irWrite, regWrite, memWrite) held 0 while reset_n=0.
REQ-034 Reset asserted mid-instruction, including during a MEMWRITE wait, SHALL abandon the instruction; the first rising clock edge after reset_n rises SHALL begin in FETCH.

Structure
REQ-035 A shared package SHALL hold: state enum, opcode and funct constants, and aluControl codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT. The single-cycle control SHALL use the same package.
REQ-036 The funct-to-aluControl decode SHALL be a separate combinational sub-module, alu_decoder, which also outputs a legal flag.
REQ-037 The FSM SHALL use one state register with next-state logic and output logic in separate combinational blocks.

Verification
REQ-038 Reset, then lw with memReady=1 always -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regWrite=1 only in cycle 5, with memToReg=01.
REQ-039 sw with memReady low for 3 cycles in MEMWRITE -> memWrite=1 for 4 consecutive cycles, then FETCH.
REQ-040 beq with zero=1 -> pcEn=1, pcSrc=01 in BRANCH; same instruction with zero=0 -> pcEn=0.
REQ-041 jal -> regWrite=1, regDst=10, memToReg=10, pcEn=1, pcSrc=10 in the same cycle.
REQ-042 opcode 111111, then R-type with funct 000000 -> illegalOp pulses once each, FSM returns to FETCH, no regWrite.
REQ-043 reset_n dropped mid-MEMWRITE -> memWrite falls without any clock edge; after release, state=FETCH.
